div3_serial: RTL and testbench

DIV3_SERIAL -- requirements
Module: div3_serial

---
 rtl/div3_serial.sv | 109 ++++++++++
 tb/tb_div3_serial.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/div3_serial.sv
// rtl/div3_serial.sv - serial LSB-first exact divide-by-3 (q = n * inv(3) mod 2^W); optional remainder check via DIV3_SERIAL_REM_CHECK_EN
module div3_serial #(
  parameter int W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic data,
  output logic out_valid,
  output logic out,
  output logic frame_done,
  output logic rem_err
);

  localparam int CW = $clog2(W);

  // FSM state encodes {previous quotient bit, carry}
  localparam logic [1:0] S00 = 2'b00;
  localparam logic [1:0] S01 = 2'b01;
  localparam logic [1:0] S10 = 2'b10;
  localparam logic [1:0] S11 = 2'b11;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          qp;
  logic          c;
  logic          q_bit;
  logic          c_nxt;
  logic          last_bit;

  // Decode state, then solve n_i = q_i + q_{i-1} + carry for q_i
  always_comb begin
    qp = 1'b0;
    c  = 1'b0;
    case (state)
      S00:     begin qp = 1'b0; c = 1'b0; end
      S01:     begin qp = 1'b0; c = 1'b1; end
      S10:     begin qp = 1'b1; c = 1'b0; end
      S11:     begin qp = 1'b1; c = 1'b1; end
      default: begin qp = 1'b0; c = 1'b0; end
    endcase
    q_bit    = data ^ qp ^ c;
    c_nxt    = (q_bit & qp) | (q_bit & c) | (qp & c);
    last_bit = (cnt == CW'(W - 1));
  end

  // Accept one dividend bit per valid cycle; the final bit rewinds the frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S00;
      cnt        <= '0;
      out        <= 1'b0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (in_valid) begin
        out       <= q_bit;
        out_valid <= 1'b1;
        if (last_bit) begin
          state      <= S00;
          cnt        <= '0;
          frame_done <= 1'b1;
        end else begin
          state <= {q_bit, c_nxt};
          cnt   <= cnt + 1'b1;
        end
      end else begin
        out       <= 1'b0;
        out_valid <= 1'b0;
      end
    end
  end

`ifdef DIV3_SERIAL_REM_CHECK_EN
  logic [1:0] residue;
  logic [1:0] addend;
  logic [2:0] res_sum;
  logic [1:0] res_nxt;

  // 2^i mod 3 alternates 1,2 so the bit weight follows counter parity
  always_comb begin
    addend  = data ? (cnt[0] ? 2'd2 : 2'd1) : 2'd0;
    res_sum = {1'b0, residue} + {1'b0, addend};
    res_nxt = (res_sum >= 3'd3) ? 2'(res_sum - 3'd3) : res_sum[1:0];
  end

  // Accumulate residue; flag a nonzero final residue alongside frame_done
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      residue <= 2'd0;
      rem_err <= 1'b0;
    end else begin
      rem_err <= 1'b0;
      if (in_valid) begin
        if (last_bit) begin
          residue <= 2'd0;
          rem_err <= (res_nxt != 2'd0);
        end else begin
          residue <= res_nxt;
        end
      end
    end
  end
`else
  assign rem_err = 1'b0;
`endif

endmodule

// File: tb/tb_div3_serial.sv
// tb/tb_div3_serial.sv - scoreboard bench for div3_serial (W=8)
module tb_div3_serial;

  logic clk;
  logic reset;
  logic in_valid;
  logic data;
  logic out_valid;
  logic out;
  logic frame_done;
  logic rem_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int frames = 0;
  int last_done = 0;
  int prev_done = 0;
  int bitpos = 0;
  logic [7:0] qacc = '0;

  typedef struct {
    logic [7:0] n;
    logic [7:0] q;
    logic       rem;
  } exp_t;

  exp_t sb[$];

  div3_serial #(.W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .data       (data),
    .out_valid  (out_valid),
    .out        (out),
    .frame_done (frame_done),
    .rem_err    (rem_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t make_exp(input logic [7:0] n);
    exp_t e;
    e.n = n;
    e.q = 8'(int'(n) * 171);
`ifdef DIV3_SERIAL_REM_CHECK_EN
    e.rem = ((int'(n) % 3) != 0);
`else
    e.rem = 1'b0;
`endif
    return e;
  endfunction

  // Collect quotient bits and retire one scoreboard entry per frame_done
  always @(negedge clk) begin
    if (reset) begin
      bitpos = 0;
      qacc   = '0;
    end else begin
      if (out_valid) begin
        if (bitpos < 8) qacc[bitpos] = out;
        bitpos++;
      end else begin
        chk("out_zero_when_idle", int'(out), 0);
      end
      if (frame_done) begin
        exp_t e;
        frames++;
        prev_done = last_done;
        last_done = cyc;
        chk("frame_bit_count", bitpos, 8);
        if (sb.size() == 0) begin
          chk("unexpected_frame_done", 0, 1);
        end else begin
          e = sb.pop_front();
          chk($sformatf("q_n%0d", e.n), int'(qacc), int'(e.q));
          chk($sformatf("q_times3_n%0d", e.n), (int'(qacc) * 3) % 256, int'(e.n));
          chk($sformatf("rem_err_n%0d", e.n), int'(rem_err), int'(e.rem));
        end
        bitpos = 0;
        qacc   = '0;
      end else begin
        chk("rem_err_outside_done", int'(rem_err), 0);
      end
    end
  end

  task automatic send_bit(input logic v, input logic d);
    in_valid = v;
    data     = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) send_bit(1'b0, 1'b0);
  endtask

  task automatic send_frame(input logic [7:0] n, input int gap_at, input int gap_len,
                            input bit rnd, output int start_cyc);
    sb.push_back(make_exp(n));
    start_cyc = 0;
    for (int i = 0; i < 8; i++) begin
      send_bit(1'b1, n[i]);
      if (i == 0) start_cyc = cyc;
      if (i == gap_at) idle(gap_len);
      if (rnd && i < 7 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
  endtask

  initial begin
    int st;
    int frames_before;
    logic [7:0] abort_n;
    in_valid = 1'b0;
    data     = 1'b0;
    reset    = 1'b1;
    #2;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out", int'(out), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    chk("reset_rem_err", int'(rem_err), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(2);

    // n=9 continuous -> q=3
    send_frame(8'd9, -1, 0, 1'b0, st);
    idle(3);
    chk("frames_after_9", frames, 1);

    // 255 then 27 back-to-back
    send_frame(8'd255, -1, 0, 1'b0, st);
    send_frame(8'd27, -1, 0, 1'b0, st);
    idle(3);
    chk("back_to_back_spacing", last_done - prev_done, 8);

    // n=10 not divisible
    send_frame(8'd10, -1, 0, 1'b0, st);
    idle(3);

    // n=9 with a 3-cycle gap after bit 2
    send_frame(8'd9, 2, 3, 1'b0, st);
    idle(3);
    chk("gap_done_latency", last_done - st, 10);

    // reset mid-frame discards partial 255
    abort_n = 8'd255;
    frames_before = frames;
    for (int i = 0; i < 5; i++) send_bit(1'b1, abort_n[i]);
    reset = 1'b1;
    #1;
    chk("midreset_out_valid", int'(out_valid), 0);
    chk("midreset_out", int'(out), 0);
    chk("midreset_frame_done", int'(frame_done), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_frame(8'd6, -1, 0, 1'b0, st);
    idle(3);
    chk("single_done_after_reset", frames - frames_before, 1);

    // exhaustive sweep with random gaps
    for (int n = 0; n < 256; n++) begin
      send_frame(8'(n), -1, 0, 1'b1, st);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(3);
    for (int k = 0; k < 20 && sb.size() != 0; k++) idle(1);
    chk("scoreboard_drained", sb.size(), 0);
    chk("total_frames", frames, 262);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
